// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, writeback source selects, load sizes
// and the writeback-stage state type.
package riscv_pkg;

  localparam logic [6:0] I1  = 7'b0000011;
  localparam logic [6:0] I2  = 7'b0010011;
  localparam logic [6:0] S   = 7'b0100011;
  localparam logic [6:0] R   = 7'b0110011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] J   = 7'b1101111;
  localparam logic [6:0] JR  = 7'b1100111;
  localparam logic [6:0] U   = 7'b0110111;
  localparam logic [6:0] UPC = 7'b0010111;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] WB_IMM  = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    COMMIT    = 2'd2
  } wb_state_t;

  // Non-load writeback value; WB_LOAD never reaches this path.
  function automatic logic [31:0] wb_mux(input logic [1:0]  sel,
                                         input logic [31:0] alu,
                                         input logic [31:0] pc4,
                                         input logic [31:0] imm);
    case (sel)
      WB_PC4:  return pc4;
      WB_IMM:  return imm;
      default: return alu;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half/word lane out of a raw memory word and
// sign- or zero-extends it according to the load funct3.
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (addr)
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
  end

  // Halfword lane ignores addr[0]; misaligned halves read the containing half.
  assign w_half = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    case (funct3)
      F3_LB:   result = {{24{w_byte[7]}}, w_byte};
      F3_LH:   result = {{16{w_half[15]}}, w_half};
      F3_LBU:  result = {24'd0, w_byte};
      F3_LHU:  result = {16'd0, w_half};
      default: result = mem_rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: accepts retiring instructions, waits for load data,
// drives the register-file write port and counts retired instructions.
module wb_stage
  import riscv_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 16,
  parameter int CNT_W        = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rd,
  input  logic             in_reg_write,
  input  logic [1:0]       in_wb_sel,
  input  logic [2:0]       in_funct3,
  input  logic [31:0]      in_alu_result,
  input  logic [31:0]      in_pc_4,
  input  logic [31:0]      in_imm,
  input  logic             mem_rvalid,
  input  logic [31:0]      mem_rdata,
  output logic             RegWrite,
  output logic [4:0]       rd_WB,
  output logic [31:0]      Data_WB,
  output logic             load_err,
  output logic [CNT_W-1:0] instret
);

  localparam int CW = $clog2(LOAD_TIMEOUT + 1);

  wb_state_t      r_state;
  logic [4:0]     r_rd;
  logic           r_reg_write;
  logic [2:0]     r_funct3;
  logic [1:0]     r_addr;
  logic [CW-1:0]  r_cnt;

  logic           w_accept;
  logic           w_is_load;
  logic [31:0]    w_aligned;

  assign in_ready  = (r_state != LOAD_WAIT);
  assign w_accept  = in_valid & in_ready;
  assign w_is_load = (in_wb_sel == WB_LOAD);

  load_align u_load_align (
    .mem_rdata (mem_rdata),
    .addr      (r_addr),
    .funct3    (r_funct3),
    .result    (w_aligned)
  );

  // Outputs are registered on the edge that enters COMMIT, so the commit
  // cycle is the one in which state==COMMIT and RegWrite/load_err may pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_funct3    <= '0;
      r_addr      <= '0;
      r_cnt       <= '0;
      RegWrite    <= 1'b0;
      rd_WB       <= '0;
      Data_WB     <= '0;
      load_err    <= 1'b0;
      instret     <= '0;
    end else begin
      RegWrite <= 1'b0;
      load_err <= 1'b0;
      case (r_state)
        LOAD_WAIT: begin
          if (mem_rvalid) begin
            r_state  <= COMMIT;
            RegWrite <= r_reg_write & (r_rd != 5'd0);
            rd_WB    <= r_rd;
            Data_WB  <= w_aligned;
            instret  <= instret + CNT_W'(1);
          end else if (r_cnt == CW'(LOAD_TIMEOUT - 1)) begin
            r_state  <= COMMIT;
            RegWrite <= r_reg_write & (r_rd != 5'd0);
            rd_WB    <= r_rd;
            Data_WB  <= '0;
            load_err <= 1'b1;
            instret  <= instret + CNT_W'(1);
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          if (w_accept) begin
            if (w_is_load) begin
              r_state     <= LOAD_WAIT;
              r_rd        <= in_rd;
              r_reg_write <= in_reg_write;
              r_funct3    <= in_funct3;
              r_addr      <= in_alu_result[1:0];
              r_cnt       <= '0;
            end else begin
              r_state  <= COMMIT;
              RegWrite <= in_reg_write & (in_rd != 5'd0);
              rd_WB    <= in_rd;
              Data_WB  <= wb_mux(in_wb_sel, in_alu_result, in_pc_4, in_imm);
              instret  <= instret + CNT_W'(1);
            end
          end else begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Randomized self-checking bench for wb_stage against a transaction-level
// model of writeback values, commit timing and the retired count.
module tb_wb_stage;

  localparam int LT = 16;

  logic        clock;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [4:0]  inRd;
  logic        inRegWrite;
  logic [1:0]  inWbSel;
  logic [2:0]  inFunct3;
  logic [31:0] inAlu;
  logic [31:0] inPc4;
  logic [31:0] inImm;
  logic        memRvalid;
  logic [31:0] memRdata;
  logic        wbRegWrite;
  logic [4:0]  wbRd;
  logic [31:0] wbData;
  logic        loadErr;
  logic [63:0] instret;

  int          checkCount;
  int          errorCount;
  logic [63:0] expCount;
  logic [31:0] lastData;
  logic [4:0]  lastRd;

  wb_stage #(.LOAD_TIMEOUT(LT), .CNT_W(64)) dut (
    .clk           (clock),
    .rst           (reset),
    .in_valid      (inValid),
    .in_ready      (inReady),
    .in_rd         (inRd),
    .in_reg_write  (inRegWrite),
    .in_wb_sel     (inWbSel),
    .in_funct3     (inFunct3),
    .in_alu_result (inAlu),
    .in_pc_4       (inPc4),
    .in_imm        (inImm),
    .mem_rvalid    (memRvalid),
    .mem_rdata     (memRdata),
    .RegWrite      (wbRegWrite),
    .rd_WB         (wbRd),
    .Data_WB       (wbData),
    .load_err      (loadErr),
    .instret       (instret)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Expected load result from the memory word, written as shifts and masks.
  function automatic logic [31:0] loadValue(input logic [31:0] word, input logic [1:0] addr,
                                            input logic [2:0] f3);
    logic [31:0] b;
    logic [31:0] h;
    b = (word >> (int'(addr) * 8)) & 32'h0000_00FF;
    h = (word >> (addr[1] ? 16 : 0)) & 32'h0000_FFFF;
    case (f3)
      3'b000:  return (b >= 32'd128)   ? b - 32'd256   : b;
      3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return word;
    endcase
  endfunction

  // Sends one instruction and checks its commit; waitCycles is the LOAD_WAIT
  // cycle index carrying rvalid (>= LT means memory never answers).
  task automatic applyStimulus(input logic [4:0] rd, input logic regWr, input logic [1:0] sel,
                               input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc4,
                               input logic [31:0] imm, input logic [31:0] word, input int waitCycles);
    logic [31:0] expData;
    logic        expErr;
    int          lat;
    checkOutput("acceptReady", 64'(inReady), 64'(1));
    inValid = 1'b1; inRd = rd; inRegWrite = regWr; inWbSel = sel;
    inFunct3 = f3; inAlu = alu; inPc4 = pc4; inImm = imm;
    @(posedge clock); #1;
    inValid = 1'b0;
    inAlu = $urandom(); inRd = 5'($urandom());
    expErr = 1'b0;
    if (sel == 2'b00)      expData = alu;
    else if (sel == 2'b10) expData = pc4;
    else if (sel == 2'b11) expData = imm;
    else begin
      if (waitCycles < LT) begin
        lat = waitCycles + 1;
        expData = loadValue(word, alu[1:0], f3);
      end else begin
        lat = LT;
        expData = 32'd0;
        expErr = 1'b1;
      end
      for (int i = 0; i < lat; i++) begin
        checkOutput("waitReady", 64'(inReady), 64'(0));
        checkOutput("waitNoWrite", 64'(wbRegWrite), 64'(0));
        memRvalid = (i == waitCycles);
        memRdata  = (i == waitCycles) ? word : $urandom();
        @(posedge clock); #1;
        memRvalid = 1'b0;
      end
    end
    expCount = expCount + 64'd1;
    checkOutput("commitRegWrite", 64'(wbRegWrite), 64'(regWr && (rd != 5'd0)));
    checkOutput("commitRd", 64'(wbRd), 64'(rd));
    checkOutput("commitData", 64'(wbData), 64'(expData));
    checkOutput("commitLoadErr", 64'(loadErr), 64'(expErr));
    checkOutput("commitInstret", instret, expCount);
    lastData = expData;
    lastRd = rd;
  endtask

  // Idle cycles with stray rvalid pulses that must not disturb anything.
  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      memRvalid = 1'($urandom_range(0, 1));
      memRdata  = $urandom();
      @(posedge clock); #1;
      memRvalid = 1'b0;
      checkOutput("idleNoWrite", 64'(wbRegWrite), 64'(0));
      checkOutput("idleNoErr", 64'(loadErr), 64'(0));
      checkOutput("idleHoldData", 64'(wbData), 64'(lastData));
      checkOutput("idleHoldRd", 64'(wbRd), 64'(lastRd));
      checkOutput("idleInstret", instret, expCount);
      checkOutput("idleReady", 64'(inReady), 64'(1));
    end
  endtask

  initial begin
    logic [1:0] rSel;
    logic [2:0] rF3;
    logic [31:0] rAlu;
    int rWait;
    checkCount = 0; errorCount = 0;
    expCount = 64'd0; lastData = 32'd0; lastRd = 5'd0;
    reset = 1'b1; inValid = 1'b0; inRd = '0; inRegWrite = 1'b0; inWbSel = '0;
    inFunct3 = '0; inAlu = '0; inPc4 = '0; inImm = '0; memRvalid = 1'b0; memRdata = '0;

    repeat (2) @(posedge clock);
    #1;
    checkOutput("rstRegWrite", 64'(wbRegWrite), 64'(0));
    checkOutput("rstRd", 64'(wbRd), 64'(0));
    checkOutput("rstData", 64'(wbData), 64'(0));
    checkOutput("rstLoadErr", 64'(loadErr), 64'(0));
    checkOutput("rstInstret", instret, 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    checkOutput("rstReady", 64'(inReady), 64'(1));

    applyStimulus(5'd5, 1'b1, 2'b00, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 32'h0, 0);
    idleCycles(1);
    applyStimulus(5'd0, 1'b1, 2'b00, 3'b000, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 0);
    idleCycles(1);
    applyStimulus(5'd7, 1'b1, 2'b01, 3'b000, 32'h0000_1001, 32'h0, 32'h0, 32'h0000_8000, 3);
    idleCycles(1);
    applyStimulus(5'd9, 1'b1, 2'b01, 3'b101, 32'h0000_2002, 32'h0, 32'h0, 32'hBEEF_0000, 1);
    idleCycles(1);
    applyStimulus(5'd11, 1'b1, 2'b01, 3'b010, 32'h0000_3000, 32'h0, 32'h0, 32'h1234_5678, LT);
    idleCycles(1);
    applyStimulus(5'd1, 1'b1, 2'b10, 3'b000, 32'h0, 32'h0000_0104, 32'h0, 32'h0, 0);
    applyStimulus(5'd2, 1'b1, 2'b11, 3'b000, 32'h0, 32'h0, 32'hABCD_E000, 32'h0, 0);
    idleCycles(1);

    for (int n = 0; n < 60; n++) begin
      rSel = 2'($urandom_range(0, 3));
      rF3  = 3'($urandom_range(0, 7));
      rAlu = $urandom();
      rWait = ($urandom_range(0, 9) == 0) ? LT + int'($urandom_range(0, 2)) : int'($urandom_range(0, LT - 1));
      applyStimulus(5'($urandom()), 1'($urandom()), rSel, rF3, rAlu, $urandom(), $urandom(),
                    $urandom(), rWait);
      idleCycles(int'($urandom_range(0, 2)));
    end

    inValid = 1'b1; inRd = 5'd12; inRegWrite = 1'b1; inWbSel = 2'b01;
    inFunct3 = 3'b010; inAlu = 32'h0000_4000;
    @(posedge clock); #1;
    inValid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    checkOutput("midRstRegWrite", 64'(wbRegWrite), 64'(0));
    checkOutput("midRstRd", 64'(wbRd), 64'(0));
    checkOutput("midRstData", 64'(wbData), 64'(0));
    checkOutput("midRstLoadErr", 64'(loadErr), 64'(0));
    checkOutput("midRstInstret", instret, 64'd0);
    expCount = 64'd0; lastData = 32'd0; lastRd = 5'd0;
    @(posedge clock); #1;
    reset = 1'b0;
    idleCycles(LT + 2);
    applyStimulus(5'd3, 1'b1, 2'b00, 3'b000, 32'h0000_00AA, 32'h0, 32'h0, 32'h0, 0);
    idleCycles(1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the pipelined RV32I core.
- Takes retiring instructions from the MEM stage through a valid/ready handshake and waits for the data-memory load response when needed.
- Aligns and sign-extends load data, then drives the register-file write port (RegWrite, rd_WB, Data_WB) that the decode stage's register file consumes.
- Also keeps the retired-instruction counter.

Parameters:
- LOAD_TIMEOUT, 16, max cycles spent in LOAD_WAIT before a forced commit with error.
- CNT_W, 64, width of the instret counter.

Ports:
- clk  input  1  core clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  MEM stage presents an instruction.
- in_ready  output  1  stage can accept this cycle.
- in_rd  input  5  destination register.
- in_reg_write  input  1  instruction writes rd.
- in_wb_sel  input  2  source: 00 ALU, 01 LOAD, 10 PC+4, 11 IMM.
- in_funct3  input  3  load size/sign (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
- in_alu_result  input  32  ALU result, or load address when in_wb_sel=01.
- in_pc_4  input  32  PC+4 (JAL/JALR link).
- in_imm  input  32  U-type immediate (LUI).
- mem_rvalid  input  1  load data valid.
- mem_rdata  input  32  raw 32-bit memory word.
- RegWrite  output  1  register-file write enable (one-cycle pulse per commit).
- rd_WB  output  5  register-file write address.
- Data_WB  output  32  register-file write data.
- load_err  output  1  one-cycle pulse when a load times out.
- instret  output  CNT_W  retired-instruction count.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE.
  - RegWrite, rd_WB, Data_WB, load_err, instret all 0.
  - in_ready=1 once rst deasserts.
- States are IDLE, LOAD_WAIT and COMMIT.
- in_ready=1 in IDLE and COMMIT, 0 in LOAD_WAIT. Acceptance = in_valid & in_ready; all in_* fields are captured on acceptance.
- Accepted non-load (in_wb_sel!=01):
  - Next state is COMMIT; result is visible the cycle after acceptance (latency 1).
  - Data_WB = alu_result / pc_4 / imm per sel.
- Accepted load:
  - Next state is LOAD_WAIT; a cycle counter is cleared.
  - On a cycle with mem_rvalid=1, capture the aligned word, then go to COMMIT. Latency = memory latency + 1.
- Load alignment (addr = captured in_alu_result[1:0]):
  - Byte lane = mem_rdata[8*addr +: 8].
  - Half lane = addr[1] ? [31:16] : [15:0]; addr[0] is ignored.
  - Word ignores addr.
  - Signed loads sign-extend from bit 7/15; unsigned loads zero-extend.
  - Undefined funct3 (011, 11x) behaves as LW.
- Timeout: if the counter reaches LOAD_TIMEOUT without mem_rvalid, go to COMMIT with Data_WB=0 and pulse load_err together with the commit cycle.
- mem_rvalid outside LOAD_WAIT is ignored.
- COMMIT:
  - RegWrite = captured reg_write & (rd!=0); an x0 write is never asserted.
  - instret increments by 1 for every committed instruction, including x0 and non-writing ones; it wraps at 2^CNT_W.
  - If a new instruction is accepted in the same cycle, next state follows that instruction's type; otherwise next state is IDLE.
  - Back-to-back non-loads therefore give RegWrite every cycle.
- Outside COMMIT: RegWrite=0 and load_err=0. rd_WB and Data_WB hold their last values.
- Reset during LOAD_WAIT: the pending load is dropped and produces no commit, and instret clears.

Decomposition:
- Shared package riscv_pkg:
  - wb_sel encodings (WB_ALU, WB_LOAD, WB_PC4, WB_IMM).
  - Load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - wb_state enum.
  - Opcode constants (I1, I2, S, R, BR, J, JR, U, UPC), shared with the decode stage.
- One combinational sub-module, load_align:
  - Inputs mem_rdata, addr[1:0], funct3.
  - Output the 32-bit extended value.
- The FSM, the counters and the capture registers stay in wb_stage.

Test Plan:
- ALU op: rd=5, sel=00, alu=0x0000_1234, accepted at cycle N -> cycle N+1 RegWrite=1, rd_WB=5, Data_WB=0x1234, instret=1.
- x0 suppression: rd=0, reg_write=1, sel=00 -> commit cycle has RegWrite=0, instret increments.
- LB signed: addr=...01, mem_rdata=0x0000_8000, rvalid after 3 cycles -> in_ready=0 during the wait, Data_WB=0xFFFF_FF80, RegWrite one cycle after rvalid.
- LHU at addr[1]=1: mem_rdata=0xBEEF_0000 -> Data_WB=0x0000_BEEF.
- Load timeout: no rvalid for LOAD_TIMEOUT cycles -> Data_WB=0, load_err=1 and RegWrite=1 in the same cycle, in_ready returns to 1.
- Back-to-back plus reset:
  - JAL (sel=10, pc_4=0x104) followed by LUI (sel=11, imm=0xABCD_E000) on consecutive cycles -> two consecutive RegWrite pulses with the correct data.
  - Asserting rst mid-LOAD_WAIT -> all outputs 0 immediately and no commit afterwards.
